linear_network_multicast_pipe: RTL

//  Pipelined successor of the combinational linear unicast chain. One register stage per node.

---
 rtl/linear_network_multicast_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/linear_network_multicast_pipe.sv
// Pipelined linear multicast network: one register stage per node, destination bitmask, per-node valid/ready.
// Optional delivery counter enabled by defining LINEAR_NET_PERF_CNT_EN.
module linear_network_multicast_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    input  logic [DATA_WIDTH-1:0]          i_data_bus,
    input  logic [NUM_NODE-1:0]            i_dest,
    output logic                           o_ready,
    output logic [NUM_NODE-1:0]            o_valid,
    output logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus,
    input  logic [NUM_NODE-1:0]            i_ready
`ifdef LINEAR_NET_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]           o_deliver_cnt
`endif
);

    logic [NUM_NODE-1:0]   stage_vld;
    logic [DATA_WIDTH-1:0] stage_data [NUM_NODE];
    logic [NUM_NODE-1:0]   stage_mask [NUM_NODE];

    logic [NUM_NODE-1:0]   eject;
    logic [NUM_NODE-1:0]   done;
    logic [NUM_NODE-1:0]   up;
    logic [NUM_NODE-1:0]   leave;
    logic [NUM_NODE-1:0]   load;
    logic [DATA_WIDTH-1:0] load_data [NUM_NODE];
    logic [NUM_NODE-1:0]   load_mask [NUM_NODE];

    // Bits strictly above node k: the destinations still reachable downstream of stage k.
    function automatic logic [NUM_NODE-1:0] above_mask(input int k);
        logic [NUM_NODE-1:0] r;
        for (int i = 0; i < NUM_NODE; i++) begin
            r[i] = (i > k);
        end
        return r;
    endfunction

    always_comb begin
        o_valid    = '0;
        eject      = '0;
        done       = '0;
        up         = '0;
        o_data_bus = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            o_valid[k] = i_en & stage_vld[k] & stage_mask[k][k];
            eject[k]   = o_valid[k] & i_ready[k];
            done[k]    = ~stage_mask[k][k] | eject[k];
            up[k]      = |(stage_mask[k] & above_mask(k));
            o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = o_valid[k] ? stage_data[k] : '0;
        end
    end

    // Ready chain resolved from the last stage back to the injection port in one pass.
    always_comb begin
        logic acc_up;
        logic lv;
        acc_up = 1'b0;
        lv     = 1'b0;
        leave  = '0;
        for (int k = NUM_NODE - 1; k >= 0; k--) begin
            lv       = i_en & stage_vld[k] & done[k] & (~up[k] | acc_up);
            leave[k] = lv;
            acc_up   = i_en & (~stage_vld[k] | lv);
        end
        o_ready = acc_up;

        load         = '0;
        load[0]      = i_valid & acc_up & (|i_dest);
        load_data[0] = i_data_bus;
        load_mask[0] = i_dest;
        for (int k = 1; k < NUM_NODE; k++) begin
            load[k]      = leave[k-1] & up[k-1];
            load_data[k] = stage_data[k-1];
            load_mask[k] = stage_mask[k-1] & above_mask(k-1);
        end
    end

    // Stage registers: a reload wins over a retire; an eject while waiting downstream clears only its own bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                stage_data[k] <= '0;
                stage_mask[k] <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < NUM_NODE; k++) begin
                if (load[k]) begin
                    stage_vld[k]  <= 1'b1;
                    stage_data[k] <= load_data[k];
                    stage_mask[k] <= load_mask[k];
                end else if (leave[k]) begin
                    stage_vld[k] <= 1'b0;
                end else if (eject[k]) begin
                    stage_mask[k][k] <= 1'b0;
                end
            end
        end
    end

`ifdef LINEAR_NET_PERF_CNT_EN
    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_NODE-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_NODE; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            o_deliver_cnt <= '0;
        end else if (i_en) begin
            o_deliver_cnt <= o_deliver_cnt + popcount(eject);
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt_width;
    assign unused_cnt_width = '0;
`endif

endmodule
